// File: rtl/push_debouncer.sv
// -----------------------------------------------------------------------------
// push_debouncer
//   Turns raw active-low push buttons into clean active-low levels for the
//   up/down counter's push input. Each button has its own 2-flop
//   synchroniser, a debounce filter, a one-cycle press pulse and an optional
//   auto-repeat. The buttons do not interact with each other.
//
// Parameters
//   N_BTN       number of buttons
//   DEB_CYC     consecutive stable synchronised cycles needed to accept a
//               level change (>=1)
//   REPEAT_DLY  cycles held after an accepted press before the first repeat
//               pulse; 0 disables auto-repeat
//   REPEAT_PER  cycles between repeat pulses (>=1)
//
// Ports
//   i_Clk    in   1      clock, rising edge
//   i_Rst    in   1      asynchronous reset, active-low
//   i_Btn    in   N_BTN  raw button pins, active-low, asynchronous, may bounce
//   o_Push   out  N_BTN  debounced level, active-low (0 = pressed)
//   o_Pulse  out  N_BTN  one-cycle high pulse per accepted press and repeat
//   o_Held   out  N_BTN  high while the button is in auto-repeat
// -----------------------------------------------------------------------------
module push_debouncer #(
   parameter int N_BTN      = 2,
   parameter int DEB_CYC    = 4,
   parameter int REPEAT_DLY = 20,
   parameter int REPEAT_PER = 8
) (
   input  logic             i_Clk,
   input  logic             i_Rst,
   input  logic [N_BTN-1:0] i_Btn,
   output logic [N_BTN-1:0] o_Push,
   output logic [N_BTN-1:0] o_Pulse,
   output logic [N_BTN-1:0] o_Held
);

   localparam int T_MAX = (DEB_CYC >= REPEAT_DLY) ?
                          ((DEB_CYC >= REPEAT_PER) ? DEB_CYC : REPEAT_PER) :
                          ((REPEAT_DLY >= REPEAT_PER) ? REPEAT_DLY : REPEAT_PER);
   localparam int TW = $clog2(T_MAX + 1);

   localparam logic [TW-1:0] T_ONE = TW'(1);
   localparam logic [TW-1:0] T_DEB = TW'(DEB_CYC - 1);
   localparam logic [TW-1:0] T_RPD = TW'((REPEAT_DLY == 0) ? 0 : REPEAT_DLY - 1);
   localparam logic [TW-1:0] T_RPP = TW'(REPEAT_PER - 1);

   typedef enum logic [2:0] {
      S_UP,
      S_DN_CHK,
      S_DOWN,
      S_RPT,
      S_UP_CHK
   } state_t;

   // The timer parks at all-ones instead of wrapping, so a long stay in a
   // state can never alias back onto a compare value.
   function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
      return (t == '1) ? t : t + T_ONE;
   endfunction

   logic [N_BTN-1:0] sync_p0;
   logic [N_BTN-1:0] sync_p1;

   // Stage p0 -> p1: two-flop synchroniser; released (1) out of reset.
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         sync_p0 <= '1;
         sync_p1 <= '1;
      end else begin
         sync_p0 <= i_Btn;
         sync_p1 <= sync_p0;
      end
   end

   // Stage p1 -> outputs: per-button debounce / repeat FSM, registered outputs.
   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      state_t        state;
      logic [TW-1:0] tmr;
      logic          push_q;
      logic          pulse_q;
      logic          held_q;
      logic          s;

      assign s = sync_p1[i];

      always_ff @(posedge i_Clk or negedge i_Rst) begin
         if (!i_Rst) begin
            state   <= S_UP;
            tmr     <= '0;
            push_q  <= 1'b1;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
         end else begin
            pulse_q <= 1'b0;
            case (state)
               S_UP: begin
                  if (!s) begin
                     // With a one-cycle filter the first low sample is enough.
                     if (DEB_CYC == 1) begin
                        state   <= S_DOWN;
                        tmr     <= '0;
                        push_q  <= 1'b0;
                        pulse_q <= 1'b1;
                     end else begin
                        state <= S_DN_CHK;
                        tmr   <= T_ONE;
                     end
                  end
               end
               S_DN_CHK: begin
                  if (s) begin
                     state <= S_UP;
                  end else if (tmr == T_DEB) begin
                     state   <= S_DOWN;
                     tmr     <= '0;
                     push_q  <= 1'b0;
                     pulse_q <= 1'b1;
                  end else begin
                     tmr <= sat_inc(tmr);
                  end
               end
               S_DOWN, S_RPT: begin
                  if (s) begin
                     held_q <= 1'b0;
                     if (DEB_CYC == 1) begin
                        state  <= S_UP;
                        push_q <= 1'b1;
                     end else begin
                        state <= S_UP_CHK;
                        tmr   <= T_ONE;
                     end
                  end else if (state == S_DOWN) begin
                     if ((REPEAT_DLY != 0) && (tmr == T_RPD)) begin
                        state   <= S_RPT;
                        tmr     <= '0;
                        pulse_q <= 1'b1;
                        held_q  <= 1'b1;
                     end else begin
                        tmr <= sat_inc(tmr);
                     end
                  end else if (tmr == T_RPP) begin
                     tmr     <= '0;
                     pulse_q <= 1'b1;
                  end else begin
                     tmr <= sat_inc(tmr);
                  end
               end
               S_UP_CHK: begin
                  // A low sample here is bounce: back to held, and the repeat
                  // delay starts over from zero.
                  if (!s) begin
                     state <= S_DOWN;
                     tmr   <= '0;
                  end else if (tmr == T_DEB) begin
                     state  <= S_UP;
                     push_q <= 1'b1;
                  end else begin
                     tmr <= sat_inc(tmr);
                  end
               end
               default: begin
                  state   <= S_UP;
                  tmr     <= '0;
                  push_q  <= 1'b1;
                  held_q  <= 1'b0;
               end
            endcase
         end
      end

      assign o_Push[i]  = push_q;
      assign o_Pulse[i] = pulse_q;
      assign o_Held[i]  = held_q;
   end

endmodule

// File: tb/tb_push_debouncer.sv
module tb_push_debouncer;

   logic       i_Clk;
   logic       i_Rst;
   logic [1:0] i_Btn;
   logic [1:0] o_Push;
   logic [1:0] o_Pulse;
   logic [1:0] o_Held;

   int n_checks;
   int n_fail;
   int cyc;

   push_debouncer #(
      .N_BTN     (2),
      .DEB_CYC   (4),
      .REPEAT_DLY(20),
      .REPEAT_PER(8)
   ) dut (
      .i_Clk  (i_Clk),
      .i_Rst  (i_Rst),
      .i_Btn  (i_Btn),
      .o_Push (o_Push),
      .o_Pulse(o_Pulse),
      .o_Held (o_Held)
   );

   initial begin
      i_Clk = 1'b0;
      forever #5 i_Clk = ~i_Clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0] btn;
      logic [1:0] push;
      logic [1:0] pulse;
      logic [1:0] held;
      int         n;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic [1:0] btn, input logic [1:0] push,
                               input logic [1:0] pulse, input logic [1:0] held,
                               input int n);
      vec_t v;
      v.btn = btn; v.push = push; v.pulse = pulse; v.held = held; v.n = n;
      vecs.push_back(v);
   endfunction

   task automatic tick();
      @(posedge i_Clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [1:0] ep,
                      input logic [1:0] epl, input logic [1:0] eh);
      n_checks++;
      if (o_Push !== ep || o_Pulse !== epl || o_Held !== eh) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got push=%b pulse=%b held=%b, expected push=%b pulse=%b held=%b",
                  name, cyc, o_Push, o_Pulse, o_Held, ep, epl, eh);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;

      // Clean press of btn0 held 10 cycles, then release.
      add(2'b10, 2'b11, 2'b00, 2'b00, 6);
      add(2'b10, 2'b10, 2'b01, 2'b00, 1);
      add(2'b10, 2'b10, 2'b00, 2'b00, 3);
      add(2'b11, 2'b10, 2'b00, 2'b00, 6);
      add(2'b11, 2'b11, 2'b00, 2'b00, 4);
      // Press-side bounce: 3 low, 1 high, 3 low.
      add(2'b10, 2'b11, 2'b00, 2'b00, 3);
      add(2'b11, 2'b11, 2'b00, 2'b00, 1);
      add(2'b10, 2'b11, 2'b00, 2'b00, 3);
      add(2'b11, 2'b11, 2'b00, 2'b00, 10);
      // Release-side bounce while held restarts the repeat delay.
      add(2'b10, 2'b11, 2'b00, 2'b00, 6);
      add(2'b10, 2'b10, 2'b01, 2'b00, 1);
      add(2'b10, 2'b10, 2'b00, 2'b00, 3);
      add(2'b11, 2'b10, 2'b00, 2'b00, 3);
      add(2'b10, 2'b10, 2'b00, 2'b00, 23);
      add(2'b10, 2'b10, 2'b01, 2'b01, 1);
      add(2'b10, 2'b10, 2'b00, 2'b01, 1);
      add(2'b11, 2'b10, 2'b00, 2'b01, 3);
      add(2'b11, 2'b10, 2'b00, 2'b00, 3);
      add(2'b11, 2'b11, 2'b00, 2'b00, 3);
      // Both buttons pressed in the same cycle.
      add(2'b00, 2'b11, 2'b00, 2'b00, 6);
      add(2'b00, 2'b00, 2'b11, 2'b00, 1);
      add(2'b00, 2'b00, 2'b00, 2'b00, 3);
      add(2'b11, 2'b00, 2'b00, 2'b00, 6);
      add(2'b11, 2'b11, 2'b00, 2'b00, 3);

      // Reset with buttons pressed: outputs clear asynchronously.
      i_Btn = 2'b00;
      i_Rst = 1'b1;
      #2 i_Rst = 1'b0;
      #1 chk("reset_async", 2'b11, 2'b00, 2'b00);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("reset_hold", 2'b11, 2'b00, 2'b00);
      end
      i_Btn = 2'b11;
      i_Rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("idle", 2'b11, 2'b00, 2'b00);
      end

      // Table-driven segments.
      for (int r = 0; r < vecs.size(); r++) begin
         cyc = 0;
         for (int k = 0; k < vecs[r].n; k++) begin
            i_Btn = vecs[r].btn;
            chk($sformatf("vec%0d", r), vecs[r].push, vecs[r].pulse, vecs[r].held);
            tick();
            cyc++;
         end
      end

      // Long hold of btn1: press pulse, then auto-repeat.
      for (int c = 0; c <= 70; c++) begin
         logic [1:0] ep, epl, eh;
         cyc   = c;
         i_Btn = (c < 60) ? 2'b01 : 2'b11;
         ep    = (c >= 6 && c < 66) ? 2'b01 : 2'b11;
         epl   = (c == 6 || c == 26 || c == 34 || c == 42 || c == 50 || c == 58) ? 2'b10 : 2'b00;
         eh    = (c >= 26 && c < 63) ? 2'b10 : 2'b00;
         chk("hold_repeat", ep, epl, eh);
         tick();
      end

      // Reset in the middle of a held press, button still low afterwards.
      for (int c = 0; c <= 30; c++) begin
         logic [1:0] ep, epl, eh;
         cyc   = c;
         i_Btn = 2'b10;
         ep    = (c >= 6) ? 2'b10 : 2'b11;
         epl   = (c == 6 || c == 26) ? 2'b01 : 2'b00;
         eh    = (c >= 26) ? 2'b01 : 2'b00;
         chk("pre_reset", ep, epl, eh);
         if (c < 30) tick();
      end
      #1 i_Rst = 1'b0;
      #1 chk("midpress_reset_async", 2'b11, 2'b00, 2'b00);
      for (int c = 31; c <= 35; c++) begin
         tick();
         cyc = c;
         chk("in_reset", 2'b11, 2'b00, 2'b00);
      end
      #1 i_Rst = 1'b1;
      for (int c = 36; c <= 55; c++) begin
         logic [1:0] ep, epl;
         tick();
         cyc   = c;
         i_Btn = (c < 46) ? 2'b10 : 2'b11;
         ep    = (c >= 41 && c < 52) ? 2'b10 : 2'b11;
         epl   = (c == 41) ? 2'b01 : 2'b00;
         chk("post_reset_press", ep, epl, 2'b00);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
